// File: rtl/spi_ram_ctrl_pkg.sv
// Shared types for the SPI RAM controller: opcodes, address-validity states
// and small state helpers.
package spi_ram_ctrl_pkg;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE,
    WA,
    RA,
    WRA
  } ram_state_e;

  // True when a write address has been loaded since reset.
  function automatic logic has_wr_addr(ram_state_e s);
    return (s == WA) || (s == WRA);
  endfunction

  // True when a read address has been loaded since reset.
  function automatic logic has_rd_addr(ram_state_e s);
    return (s == RA) || (s == WRA);
  endfunction

endpackage

// File: rtl/spi_ram_ctrl_if.sv
// Word-level link between the SPI slave (master side) and the RAM controller
// (slave side).
interface spi_ram_ctrl_if;

  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout;
  logic       tx_valid;
  logic       seq_err;

  modport master (
    output din,
    output rx_valid,
    input  dout,
    input  tx_valid,
    input  seq_err
  );

  modport slave (
    input  din,
    input  rx_valid,
    output dout,
    output tx_valid,
    output seq_err
  );

endinterface

// File: rtl/spi_ram_mem.sv
// Synchronous single-port byte array with a registered read port.
// No reset: contents and the read register persist across controller reset.
module spi_ram_mem #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);

  logic [7:0] mem [DEPTH];

  // Write and registered read share one address port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/spi_ram_ctrl.sv
// RAM controller behind the SPI slave: decodes 10-bit command words, tracks
// which addresses are loaded, and returns read bytes on dout/tx_valid.
// Optional feature macro: SPI_RAM_AUTO_INC_EN (post-increment addresses on
// data commands, wrapping at MEM_DEPTH-1).
module spi_ram_ctrl
  import spi_ram_ctrl_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_SIZE = 8
) (
  input logic           clk,
  input logic           rst_n,
  spi_ram_ctrl_if.slave bus
);

  logic                 rx_valid_q;
  logic                 accept;
  cmd_e                 cmd;
  logic [7:0]           payload;
  logic                 in_range;
  ram_state_e           state_q, state_d;
  logic [ADDR_SIZE-1:0] wr_addr_q, rd_addr_q, mem_addr;
  logic                 wr_addr_ld, rd_addr_ld, mem_we, mem_re, err_d;
  logic                 tx_valid_q, seq_err_q, rd_done_q;
  logic [7:0]           rdata;

  assign accept   = bus.rx_valid & ~rx_valid_q;
  assign cmd      = cmd_e'(bus.din[9:8]);
  assign payload  = bus.din[7:0];
  assign in_range = {24'd0, payload} < MEM_DEPTH;

  // Edge detector and FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_q <= 1'b0;
      state_q    <= IDLE;
    end else begin
      rx_valid_q <= bus.rx_valid;
      state_q    <= state_d;
    end
  end

  // Next state: only in-range address loads move the FSM.
  always_comb begin
    state_d = state_q;
    if (accept && in_range) begin
      unique case (cmd)
        CMD_WR_ADDR: state_d = has_rd_addr(state_q) ? WRA : WA;
        CMD_RD_ADDR: state_d = has_wr_addr(state_q) ? WRA : RA;
        default:     state_d = state_q;
      endcase
    end
  end

  // Command decode: address loads, memory strobes and rejections.
  always_comb begin
    wr_addr_ld = 1'b0;
    rd_addr_ld = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    err_d      = 1'b0;
    if (accept) begin
      unique case (cmd)
        CMD_WR_ADDR: begin
          wr_addr_ld = in_range;
          err_d      = ~in_range;
        end
        CMD_WR_DATA: begin
          mem_we = has_wr_addr(state_q);
          err_d  = ~has_wr_addr(state_q);
        end
        CMD_RD_ADDR: begin
          rd_addr_ld = in_range;
          err_d      = ~in_range;
        end
        CMD_RD_DATA: begin
          mem_re = has_rd_addr(state_q);
          err_d  = ~has_rd_addr(state_q);
        end
        default: err_d = 1'b0;
      endcase
    end
  end

`ifdef SPI_RAM_AUTO_INC_EN
  localparam logic [ADDR_SIZE-1:0] LastAddr = ADDR_SIZE'(MEM_DEPTH - 1);
`endif

  // Address registers; optional post-increment after each data access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_q <= '0;
      rd_addr_q <= '0;
    end else begin
      if (wr_addr_ld) begin
        wr_addr_q <= ADDR_SIZE'(payload);
`ifdef SPI_RAM_AUTO_INC_EN
      end else if (mem_we) begin
        wr_addr_q <= (wr_addr_q == LastAddr) ? '0 : wr_addr_q + 1'b1;
`endif
      end
      if (rd_addr_ld) begin
        rd_addr_q <= ADDR_SIZE'(payload);
`ifdef SPI_RAM_AUTO_INC_EN
      end else if (mem_re) begin
        rd_addr_q <= (rd_addr_q == LastAddr) ? '0 : rd_addr_q + 1'b1;
`endif
      end
    end
  end

  // Output pulses; rd_done_q masks the unreset memory read register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_valid_q <= 1'b0;
      seq_err_q  <= 1'b0;
      rd_done_q  <= 1'b0;
    end else begin
      tx_valid_q <= mem_re;
      seq_err_q  <= err_d;
      rd_done_q  <= rd_done_q | mem_re;
    end
  end

  assign mem_addr     = mem_we ? wr_addr_q : rd_addr_q;
  assign bus.dout     = rd_done_q ? rdata : 8'h00;
  assign bus.tx_valid = tx_valid_q;
  assign bus.seq_err  = seq_err_q;

  spi_ram_mem #(
    .DEPTH  (MEM_DEPTH),
    .ADDR_W (ADDR_SIZE)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (payload),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench for spi_ram_ctrl: a vector table of single frames plus
// hand-written sequences for held rx_valid, FSM rejections and reset.
module tb_spi_ram_ctrl;
  import spi_ram_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  spi_ram_ctrl_if bus_if ();

  spi_ram_ctrl #(
    .MEM_DEPTH (256),
    .ADDR_SIZE (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
    logic       exp_tx;
    logic       exp_err;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One frame: rx_valid high for one cycle, then low for one cycle.
  task automatic send(input logic [1:0] op, input logic [7:0] data, input logic etx,
                      input logic eerr, input logic [7:0] edout, input string tag);
    @(negedge clk);
    bus_if.din      = {op, data};
    bus_if.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, " tx_valid"}, {7'd0, bus_if.tx_valid}, {7'd0, etx});
    chk({tag, " seq_err"}, {7'd0, bus_if.seq_err}, {7'd0, eerr});
    chk({tag, " dout"}, bus_if.dout, edout);
    @(negedge clk);
    bus_if.rx_valid = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, " pulse end"}, {6'd0, bus_if.tx_valid, bus_if.seq_err}, 8'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    bus_if.rx_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk({tag, " rst dout"}, bus_if.dout, 8'h00);
    chk({tag, " rst pulses"}, {6'd0, bus_if.tx_valid, bus_if.seq_err}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tx_cnt;
    bus_if.din      = '0;
    bus_if.rx_valid = 1'b0;

    vecs[0]  = '{CMD_RD_DATA, 8'h00, 1'b0, 1'b1, 8'h00};
    vecs[1]  = '{CMD_WR_ADDR, 8'h3C, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{CMD_WR_DATA, 8'hA5, 1'b0, 1'b0, 8'h00};
    vecs[3]  = '{CMD_RD_ADDR, 8'h3C, 1'b0, 1'b0, 8'h00};
    vecs[4]  = '{CMD_RD_DATA, 8'h00, 1'b1, 1'b0, 8'hA5};
    vecs[5]  = '{CMD_WR_ADDR, 8'h3D, 1'b0, 1'b0, 8'hA5};
    vecs[6]  = '{CMD_WR_DATA, 8'h5C, 1'b0, 1'b0, 8'hA5};
    vecs[7]  = '{CMD_RD_ADDR, 8'h3D, 1'b0, 1'b0, 8'hA5};
    vecs[8]  = '{CMD_RD_DATA, 8'hFF, 1'b1, 1'b0, 8'h5C};
    vecs[9]  = '{CMD_RD_ADDR, 8'h3C, 1'b0, 1'b0, 8'h5C};
    vecs[10] = '{CMD_RD_DATA, 8'h00, 1'b1, 1'b0, 8'hA5};

    do_reset("init");
    for (int i = 0; i < 11; i++) begin
      send(vecs[i].op, vecs[i].data, vecs[i].exp_tx, vecs[i].exp_err, vecs[i].exp_dout,
           $sformatf("vec%0d", i));
    end

    // Held rx_valid: only the first word of the frame executes.
    do_reset("hold");
    send(CMD_WR_ADDR, 8'h10, 1'b0, 1'b0, 8'h00, "hold wa");
    @(negedge clk);
    bus_if.din      = {CMD_WR_DATA, 8'h11};
    bus_if.rx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold err%0d", i), {7'd0, bus_if.seq_err}, 8'd0);
      @(negedge clk);
      if (i == 0) bus_if.din = {CMD_WR_DATA, 8'h22};
    end
    bus_if.rx_valid = 1'b0;
    send(CMD_RD_ADDR, 8'h10, 1'b0, 1'b0, 8'h00, "hold ra");
    send(CMD_RD_DATA, 8'h00, 1'b1, 1'b0, 8'h11, "hold rd");
    @(negedge clk);
    bus_if.din      = {CMD_RD_DATA, 8'h00};
    bus_if.rx_valid = 1'b1;
    tx_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (bus_if.tx_valid) tx_cnt++;
    end
    chk("held rd tx count", 8'(tx_cnt), 8'd1);
    @(negedge clk);
    bus_if.rx_valid = 1'b0;

    // Write suppressed when only the read address is loaded.
    send(CMD_WR_ADDR, 8'h05, 1'b0, 1'b0, 8'h11, "rej wa");
    send(CMD_WR_DATA, 8'h33, 1'b0, 1'b0, 8'h11, "rej wd");
    do_reset("rej");
    send(CMD_RD_ADDR, 8'h05, 1'b0, 1'b0, 8'h00, "rej ra");
    send(CMD_WR_DATA, 8'h77, 1'b0, 1'b1, 8'h00, "rej wd77");
    send(CMD_RD_DATA, 8'h00, 1'b1, 1'b0, 8'h33, "rej rd");

    // Memory persists across a reset asserted mid-frame; the held frame
    // counts as a fresh edge once reset releases.
    send(CMD_WR_ADDR, 8'h20, 1'b0, 1'b0, 8'h33, "mid wa");
    send(CMD_WR_DATA, 8'h5A, 1'b0, 1'b0, 8'h33, "mid wd");
    @(negedge clk);
    bus_if.din      = {CMD_WR_ADDR, 8'h21};
    bus_if.rx_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid rst dout", bus_if.dout, 8'h00);
    chk("mid rst pulses", {6'd0, bus_if.tx_valid, bus_if.seq_err}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mid accept err", {7'd0, bus_if.seq_err}, 8'd0);
    @(negedge clk);
    bus_if.rx_valid = 1'b0;
    send(CMD_WR_DATA, 8'hC3, 1'b0, 1'b0, 8'h00, "mid wd21");
    send(CMD_RD_ADDR, 8'h20, 1'b0, 1'b0, 8'h00, "mid ra20");
    send(CMD_RD_DATA, 8'h00, 1'b1, 1'b0, 8'h5A, "mid rd20");
    send(CMD_RD_ADDR, 8'h21, 1'b0, 1'b0, 8'h5A, "mid ra21");
    send(CMD_RD_DATA, 8'h00, 1'b1, 1'b0, 8'hC3, "mid rd21");

`ifdef SPI_RAM_AUTO_INC_EN
    send(CMD_WR_ADDR, 8'hFF, 1'b0, 1'b0, 8'hC3, "inc wa");
    send(CMD_WR_DATA, 8'h01, 1'b0, 1'b0, 8'hC3, "inc wd1");
    send(CMD_WR_DATA, 8'h02, 1'b0, 1'b0, 8'hC3, "inc wd2");
    send(CMD_RD_ADDR, 8'hFF, 1'b0, 1'b0, 8'hC3, "inc ra");
    send(CMD_RD_DATA, 8'h00, 1'b1, 1'b0, 8'h01, "inc rd1");
    send(CMD_RD_DATA, 8'h00, 1'b1, 1'b0, 8'h02, "inc rd2");
`else
    // Without auto-increment the second write lands on the same address.
    send(CMD_WR_ADDR, 8'h40, 1'b0, 1'b0, 8'hC3, "noinc wa");
    send(CMD_WR_DATA, 8'h01, 1'b0, 1'b0, 8'hC3, "noinc wd1");
    send(CMD_WR_DATA, 8'h02, 1'b0, 1'b0, 8'hC3, "noinc wd2");
    send(CMD_RD_ADDR, 8'h40, 1'b0, 1'b0, 8'hC3, "noinc ra");
    send(CMD_RD_DATA, 8'h00, 1'b1, 1'b0, 8'h02, "noinc rd1");
    send(CMD_RD_DATA, 8'h00, 1'b1, 1'b0, 8'h02, "noinc rd2");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
